// File: rtl/tx_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_ctrl
// Function : Round-robin arbiter that shares one parallel-load serial
//            transmitter among NUM_REQ requesters and sequences its
//            load / start / busy / done handshake.
// Options  : CTRL_TIMEOUT_EN adds a transfer watchdog that reports via ERR.
// Revision : 1.0  initial release
// ============================================================================
module tx_arbiter_ctrl #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*DATA_W-1:0] DIN,
    output logic [NUM_REQ-1:0]        ACK,
    output logic                      ERR,
    output logic [NUM_REQ-1:0]        GRANT,
    output logic                      CTRL_BUSY,
    output logic [DATA_W-1:0]         TX_DIN,
    output logic                      TX_PARALLEL_LOAD,
    output logic                      TX_START,
    input  logic                      TX_BUSY,
    input  logic                      TX_DONE
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_LOAD          = 3'd1,
        S_START         = 3'd2,
        S_WAIT_DONE     = 3'd3,
        S_ACK           = 3'd4,
        S_WAIT_BUSY_LOW = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               timeout_hit;

    // Scan from last_grant+1 upward; iterating from the far end lets the
    // nearest requester overwrite earlier candidates.
    always_comb begin
        winner = last_grant;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (REQ[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (|REQ) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                next_state = S_START;
            end
            S_START: begin
                // A done pulse here means the busy pulse was missed.
                if (TX_DONE || timeout_hit) begin
                    next_state = S_ACK;
                end else if (TX_BUSY) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (TX_DONE || timeout_hit) begin
                    next_state = S_ACK;
                end
            end
            S_ACK: begin
                next_state = S_WAIT_BUSY_LOW;
            end
            S_WAIT_BUSY_LOW: begin
                if (!TX_BUSY || timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            TX_DIN     <= '0;
        end else begin
            state <= next_state;
            // The word is captured only at grant so later DIN changes
            // cannot disturb the transfer in flight.
            if ((state == S_IDLE) && (|REQ)) begin
                last_grant <= winner;
                TX_DIN     <= DIN[winner*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_onehot     = NUM_REQ'(1) << last_grant;
    assign GRANT            = ((state == S_LOAD) || (state == S_START) ||
                               (state == S_WAIT_DONE)) ? owner_onehot : '0;
    assign ACK              = (state == S_ACK) ? owner_onehot : '0;
    assign CTRL_BUSY        = (state != S_IDLE);
    assign TX_PARALLEL_LOAD = (state == S_LOAD);
    assign TX_START         = (state == S_START);

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Cleared on the cycle before START and before WAIT_BUSY_LOW, so the
    // count equals cycles spent since TX_START (or ACK) first asserted.
    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state == S_LOAD) || (state == S_ACK)) begin
                tmo_cnt <= '0;
            end else if (state != S_IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            err_q <= ((state == S_START) || (state == S_WAIT_DONE)) &&
                     !TX_DONE && timeout_hit;
        end
    end

    assign ERR = err_q;
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for tx_arbiter_ctrl with a behavioural transmitter model.
module tb_tx_arbiter_ctrl;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [NR-1:0]  REQ = '0;
    logic [NR*DW-1:0] DIN = '0;
    logic [NR-1:0]  ACK;
    logic           ERR;
    logic [NR-1:0]  GRANT;
    logic           CTRL_BUSY;
    logic [DW-1:0]  TX_DIN;
    logic           TX_PARALLEL_LOAD;
    logic           TX_START;
    logic           TX_BUSY = 1'b0;
    logic           TX_DONE = 1'b0;

    tx_arbiter_ctrl #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .REQ              (REQ),
        .DIN              (DIN),
        .ACK              (ACK),
        .ERR              (ERR),
        .GRANT            (GRANT),
        .CTRL_BUSY        (CTRL_BUSY),
        .TX_DIN           (TX_DIN),
        .TX_PARALLEL_LOAD (TX_PARALLEL_LOAD),
        .TX_START         (TX_START),
        .TX_BUSY          (TX_BUSY),
        .TX_DONE          (TX_DONE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // ---------------- transmitter model ----------------
    // mode 0: busy after m_bl, done m_dl later; mode 1: busy+done together
    // while START is still high; mode 2: busy but never done.
    int m_state = 0, m_cnt = 0, m_bl = 3, m_dl = 40, m_tail = 2, m_mode = 0;

    initial forever begin
        @(posedge CLK); #1;
        if (TX_DONE) TX_DONE = 1'b0;
        case (m_state)
            0: if (TX_START === 1'b1) begin m_state = 1; m_cnt = 0; end
            1: begin
                m_cnt++;
                if (m_cnt == m_bl) begin
                    TX_BUSY = 1'b1;
                    m_cnt = 0;
                    if (m_mode == 1) begin TX_DONE = 1'b1; m_state = 3; end
                    else m_state = 2;
                end
            end
            2: begin
                m_cnt++;
                if (m_mode != 2 && m_cnt == m_dl) begin
                    TX_DONE = 1'b1; m_state = 3; m_cnt = 0;
                end
            end
            3: begin
                m_cnt++;
                if (m_cnt >= m_tail) begin TX_BUSY = 1'b0; m_state = 0; end
            end
            default: m_state = 0;
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct { int idx; logic [31:0] word; } load_t;
    typedef struct { int idx; logic [31:0] word; bit err; } ack_t;
    load_t load_q[$];
    ack_t  ack_q[$];
    load_t le;
    ack_t  ae;

    int n_loads = 0, n_acks = 0;
    int done_cyc = -100, start_cyc = -100, fall_cyc = -100, load_cyc = -100;
    int start_run = 0, start_len = 0;
    logic prev_start = 1'b0, prev_busy = 1'b0;

    initial forever begin
        @(negedge CLK);
        if (TX_START === 1'b1 && prev_start !== 1'b1) start_cyc = cyc;
        if (TX_START === 1'b1) start_run++;
        else if (prev_start === 1'b1) begin start_len = start_run; start_run = 0; end
        if (TX_DONE) done_cyc = cyc;
        if (!TX_BUSY && prev_busy) fall_cyc = cyc;
        if (TX_PARALLEL_LOAD === 1'b1) begin
            n_loads++;
            load_cyc = cyc;
            check("load_with_start", TX_START, 0);
            check("load_while_busy", TX_BUSY, 0);
            if (load_q.size() == 0) check("unexpected_load", TX_PARALLEL_LOAD, 0);
            else begin
                le = load_q.pop_front();
                check("load_word", TX_DIN, le.word);
                check("load_grant", GRANT, 32'(1) << le.idx);
            end
        end
        if (ACK !== '0 && ACK !== 'x) begin
            n_acks++;
            if (ack_q.size() == 0) check("unexpected_ack", ACK, 0);
            else begin
                ae = ack_q.pop_front();
                check("ack_onehot", ACK, 32'(1) << ae.idx);
                check("ack_err", ERR, ae.err);
                check("ack_word", TX_DIN, ae.word);
                if (ae.err) check("ack_timeout_latency", cyc - start_cyc, TMO);
                else        check("ack_done_latency", cyc - done_cyc, 1);
            end
        end else if (ERR === 1'b1) begin
            check("err_without_ack", ERR, 0);
        end
        prev_start = TX_START;
        prev_busy  = TX_BUSY;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge CLK); #1;
    endtask

    task automatic wait_acks(int target, int budget);
        int k = 0;
        while (n_acks < target && k < budget) begin step(); k++; end
        check("wait_acks", n_acks, target);
    endtask

    task automatic wait_loads(int target, int budget);
        int k = 0;
        while (n_loads < target && k < budget) begin step(); k++; end
        check("wait_loads", n_loads, target);
    endtask

    task automatic set_din(int i, logic [31:0] w);
        DIN[i*DW +: DW] = w;
    endtask

    task automatic expect_xfer(int i, logic [31:0] w, bit with_ack, bit err);
        load_q.push_back('{idx: i, word: w});
        if (with_ack) ack_q.push_back('{idx: i, word: w, err: err});
    endtask

    task automatic reset_model();
        m_state = 0; TX_BUSY = 1'b0; TX_DONE = 1'b0;
    endtask

    task automatic check_all_zero(string name);
        check({name, "_ctrl"}, {ACK, ERR, GRANT, CTRL_BUSY, TX_PARALLEL_LOAD, TX_START}, 0);
        check({name, "_txdin"}, TX_DIN, 0);
    endtask

    initial begin : stim
        int base_l, base_a;
        RESET = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        RESET = 1'b0;
        step();

        // All requesters: rotation 0,1,2,3,0 from reset priority.
        m_bl = 3; m_dl = 10; m_tail = 2; m_mode = 0;
        for (int i = 0; i < NR; i++) set_din(i, 32'h1000_0000 + 32'(i) * 32'h0111_0111);
        for (int i = 0; i < NR; i++) expect_xfer(i, 32'h1000_0000 + 32'(i) * 32'h0111_0111, 1, 0);
        expect_xfer(0, 32'h1000_0000, 1, 0);
        base_l = n_loads; base_a = n_acks;
        REQ = 4'b1111;
        wait_loads(base_l + 5, 600);
        REQ = 4'b0000;
        wait_acks(base_a + 5, 200);
        repeat (6) step();
        check("rr_idle_after", CTRL_BUSY, 0);

        // Single requester 0 with 3-cycle busy lag and 40-cycle transfer.
        m_dl = 40;
        set_din(0, 32'hA5A5_0001);
        expect_xfer(0, 32'hA5A5_0001, 1, 0);
        base_l = n_loads; base_a = n_acks;
        REQ = 4'b0001;
        wait_acks(base_a + 1, 200);
        REQ = 4'b0000;
        check("single_load_count", n_loads - base_l, 1);
        check("single_start_len", start_len, 4);
        repeat (6) step();

        // Word captured at grant; REQ dropped after grant still completes.
        m_dl = 10;
        set_din(2, 32'hC0FF_EE02);
        expect_xfer(2, 32'hC0FF_EE02, 1, 0);
        base_l = n_loads; base_a = n_acks;
        REQ = 4'b0100;
        wait_loads(base_l + 1, 50);
        step(); step();
        set_din(2, 32'hDEAD_BEEF);
        REQ = 4'b0000;
        wait_acks(base_a + 1, 200);
        repeat (6) step();

        // Done arrives while still in START; next grant waits for busy low.
        m_mode = 1; m_bl = 2; m_tail = 6;
        set_din(3, 32'h3333_0003);
        expect_xfer(3, 32'h3333_0003, 1, 0);
        base_a = n_acks;
        REQ = 4'b1000;
        wait_acks(base_a + 1, 100);
        set_din(1, 32'h1111_0001);
        expect_xfer(1, 32'h1111_0001, 1, 0);
        base_l = n_loads;
        REQ = 4'b0010;
        m_mode = 0; m_bl = 3; m_dl = 10;
        wait_loads(base_l + 1, 100);
        check("load_after_busy_low", load_cyc - fall_cyc, 2);
        wait_acks(base_a + 2, 200);
        REQ = 4'b0000;
        m_tail = 2;
        repeat (6) step();

        // Reset mid-WAIT_DONE aborts without ACK; priority returns to 0.
        m_dl = 40;
        set_din(0, 32'h5555_0000);
        expect_xfer(0, 32'h5555_0000, 0, 0);
        base_l = n_loads;
        REQ = 4'b0001;
        wait_loads(base_l + 1, 50);
        repeat (10) step();
        check("pre_reset_grant", GRANT, 4'b0001);
        base_a = n_acks;
        RESET = 1'b1; REQ = 4'b0000; reset_model();
        step();
        check_all_zero("midreset");
        RESET = 1'b0;
        repeat (5) step();
        check("no_ack_after_abort", n_acks, base_a);
        // Both 0 and 1 request: a restored last_grant must pick 0 first.
        m_dl = 10;
        set_din(0, 32'h0A0A_0000);
        set_din(1, 32'h0B0B_0001);
        expect_xfer(0, 32'h0A0A_0000, 1, 0);
        expect_xfer(1, 32'h0B0B_0001, 1, 0);
        REQ = 4'b0011;
        wait_acks(base_a + 2, 300);
        REQ = 4'b0000;
        repeat (6) step();

        // Transmitter never signals done.
        m_mode = 2;
        set_din(2, 32'h7777_0002);
        base_a = n_acks;
`ifdef CTRL_TIMEOUT_EN
        expect_xfer(2, 32'h7777_0002, 1, 1);
        REQ = 4'b0100;
        wait_acks(base_a + 1, 200);
        REQ = 4'b0000;
        repeat (20) step();
        check("busy_low_timeout_idle", CTRL_BUSY, 0);
        reset_model();
`else
        expect_xfer(2, 32'h7777_0002, 0, 0);
        REQ = 4'b0100;
        repeat (200) step();
        check("no_ack_without_done", n_acks, base_a);
        check("still_waiting", CTRL_BUSY, 1);
        RESET = 1'b1; REQ = 4'b0000; reset_model();
        step();
        RESET = 1'b0;
`endif
        m_mode = 0;
        repeat (5) step();
        check("queues_drained", load_q.size() + ack_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
